// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the local CPU register bus master.
package cpu_bus_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int STAT_W     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// Request/response channels plus the timed CPU register bus.
interface cpu_bus_master_if #(
    parameter int ADDR_WIDTH = 16
);
    import cpu_bus_pkg::*;

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [CPU_DATA_W-1:0] req_wdata;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [CPU_DATA_W-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_rd;
    logic                  cpu_rd_dly1;
    logic                  cpu_wr;
    logic [CPU_DATA_W-1:0] cpu_data_out;
    logic [CPU_DATA_W-1:0] cpu_data_in;

    modport master (
        input  req_vld, req_wr, req_addr, req_wdata,
        output req_rdy,
        output rsp_vld, rsp_rdata,
        input  rsp_rdy,
        output cpu_addr, cpu_rd, cpu_rd_dly1, cpu_wr, cpu_data_out,
        input  cpu_data_in
    );

    modport slave (
        output req_vld, req_wr, req_addr, req_wdata,
        input  req_rdy,
        input  rsp_vld, rsp_rdata,
        output rsp_rdy,
        input  cpu_addr, cpu_rd, cpu_rd_dly1, cpu_wr, cpu_data_out,
        output cpu_data_in
    );

endinterface

// File: rtl/cpu_bus_sat_cnt.sv
// Saturating event counter; sticks at all-ones until reset.
module cpu_bus_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clks,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clks) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_master.sv
// Turns valid/ready requests into SETUP/STROBE/HOLD bus cycles.
// Define CPU_MST_STAT_EN to add saturating read/write counters.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int SETUP_CYC  = 1,
    parameter int STB_CYC    = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clks,
    input  logic              reset,
    cpu_bus_master_if.master  bus
`ifdef CPU_MST_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_wr_cnt
`endif
);

    localparam int MAXC  = max3(SETUP_CYC, STB_CYC, HOLD_CYC);
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] W_LD = CNT_W'(STB_CYC - 1);
    localparam logic [CNT_W-1:0] H_LD = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || STB_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("cpu_bus_master: phase lengths must be >= 1");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             last;
    logic             rsp_done;

    assign last     = (cnt == '0);
    assign rsp_done = bus.rsp_vld & bus.rsp_rdy;

    always_ff @(posedge clks) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            wr_q             <= 1'b0;
            bus.req_rdy      <= 1'b0;
            bus.rsp_vld      <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.cpu_addr     <= '0;
            bus.cpu_rd       <= 1'b0;
            bus.cpu_rd_dly1  <= 1'b0;
            bus.cpu_wr       <= 1'b0;
            bus.cpu_data_out <= '0;
        end else begin
            bus.cpu_rd_dly1 <= bus.cpu_rd;
            unique case (state)
                IDLE: begin
                    bus.req_rdy <= 1'b1;
                    if (bus.req_vld && bus.req_rdy) begin
                        bus.req_rdy      <= 1'b0;
                        bus.cpu_addr     <= bus.req_addr;
                        bus.cpu_data_out <= bus.req_wdata;
                        bus.rsp_rdata    <= '0;
                        wr_q             <= bus.req_wr;
                        cnt              <= S_LD;
                        state            <= SETUP;
                    end
                end
                SETUP: begin
                    if (last) begin
                        bus.cpu_rd <= ~wr_q;
                        bus.cpu_wr <= wr_q;
                        cnt        <= W_LD;
                        state      <= STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (last) begin
                        bus.cpu_rd <= 1'b0;
                        bus.cpu_wr <= 1'b0;
                        // responders drive data while cpu_rd is high
                        if (!wr_q) begin
                            bus.rsp_rdata <= bus.cpu_data_in;
                        end
                        cnt   <= H_LD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (last) begin
                        bus.rsp_vld <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        bus.rsp_vld <= 1'b0;
                        bus.req_rdy <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CPU_MST_STAT_EN
    cpu_bus_sat_cnt #(.W(STAT_W)) u_rd_cnt (
        .clks  (clks),
        .reset (reset),
        .inc   (rsp_done & ~wr_q),
        .cnt   (stat_rd_cnt)
    );

    cpu_bus_sat_cnt #(.W(STAT_W)) u_wr_cnt (
        .clks  (clks),
        .reset (reset),
        .inc   (rsp_done & wr_q),
        .cnt   (stat_wr_cnt)
    );
`endif

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with a small ts_addr_reg stand-in.
module tb_cpu_bus_master;
    import cpu_bus_pkg::*;

    logic        clks = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] drv_data = '0;
    logic        ts_en = 1'b0;
    logic [4:0]  tr_rd, tr_dly, tr_wr, tr_vld;
    logic [31:0] cap;

    cpu_bus_master_if #(.ADDR_WIDTH(16)) bus ();

`ifdef CPU_MST_STAT_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
`endif

    cpu_bus_master dut (
        .clks        (clks),
        .reset       (reset),
        .bus         (bus)
`ifdef CPU_MST_STAT_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    always #5 clks = ~clks;

    // responder at 16'h0004 returning its fixed pattern, OR-merged
    assign bus.cpu_data_in = drv_data |
        ((ts_en && bus.cpu_addr == 16'h0004) ? 32'hFEFF_FEFF : 32'h0);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata);
        int t;
        t = 0;
        while (bus.req_rdy !== 1'b1 && t < 40) begin
            @(negedge clks);
            t++;
        end
        chk("req_rdy_wait", bus.req_rdy, 1);
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clks);
        bus.req_vld = 1'b0;
    endtask

    // samples cycles 1..5 after acceptance; bit 4 is cycle 1
    task automatic trace(input logic [31:0] pat, input logic quiet);
        tr_rd = '0; tr_dly = '0; tr_wr = '0; tr_vld = '0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clks);
            tr_rd  = {tr_rd[3:0], bus.cpu_rd};
            tr_dly = {tr_dly[3:0], bus.cpu_rd_dly1};
            tr_wr  = {tr_wr[3:0], bus.cpu_wr};
            tr_vld = {tr_vld[3:0], bus.rsp_vld};
            if (quiet)
                drv_data = '0;
            else if (k == 2 || k == 3)
                drv_data = pat;
            else
                drv_data = 32'hBAD0_0000 | 32'(k);
        end
        cap = bus.rsp_rdata;
        drv_data = '0;
    endtask

    task automatic finish_rsp();
        bus.rsp_rdy = 1'b1;
        @(negedge clks);
        bus.rsp_rdy = 1'b0;
        chk("rsp_clear", bus.rsp_vld, 0);
        chk("rdy_back", bus.req_rdy, 1);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] pat,
                           input string tag);
        start(1'b0, addr, 32'h0);
        trace(pat, 1'b0);
        chk(tag, cap, {32'h0, pat});
        finish_rsp();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_rdy   = 1'b0;

        repeat (2) @(negedge clks);
        chk("rst_rsp_vld", bus.rsp_vld, 0);
        chk("rst_cpu_rd", bus.cpu_rd, 0);
        chk("rst_cpu_wr", bus.cpu_wr, 0);
        chk("rst_addr", bus.cpu_addr, 0);
        chk("rst_req_rdy", bus.req_rdy, 0);
        reset = 1'b0;
        @(negedge clks);
        chk("idle_req_rdy", bus.req_rdy, 1);

        // read with default timing
        start(1'b0, 16'h0010, 32'h0);
        chk("rd_addr", bus.cpu_addr, 16'h0010);
        trace(32'h1234_5678, 1'b0);
        chk("rd_trace", tr_rd, 5'b01100);
        chk("rd_dly_trace", tr_dly, 5'b00110);
        chk("rd_wr_trace", tr_wr, 5'b00000);
        chk("rd_vld_trace", tr_vld, 5'b00001);
        chk("rd_data", cap, 32'h1234_5678);
        finish_rsp();

        // write ignores read data
        start(1'b1, 16'h0020, 32'hDEAD_BEEF);
        chk("wr_addr", bus.cpu_addr, 16'h0020);
        chk("wr_dout", bus.cpu_data_out, 32'hDEAD_BEEF);
        trace(32'hFFFF_FFFF, 1'b0);
        chk("wr_trace", tr_wr, 5'b01100);
        chk("wr_rd_trace", tr_rd, 5'b00000);
        chk("wr_vld_trace", tr_vld, 5'b00001);
        chk("wr_rdata", cap, 0);
        finish_rsp();
        chk("wr_dout_kept", bus.cpu_data_out, 32'hDEAD_BEEF);

        // responder at 16'h0004
        ts_en = 1'b1;
        start(1'b0, 16'h0100, 32'h0);
        trace(32'h0, 1'b1);
        chk("ts_miss", cap, 0);
        finish_rsp();
        start(1'b0, 16'h0004, 32'h0);
        trace(32'h0, 1'b1);
        chk("ts_hit", cap, 32'hFEFF_FEFF);
        finish_rsp();
        ts_en = 1'b0;

        // response stall with competing request
        start(1'b0, 16'h0030, 32'h0);
        trace(32'hA5A5_5A5A, 1'b0);
        chk("stall_data0", cap, 32'hA5A5_5A5A);
        for (int i = 0; i < 10; i++) begin
            bus.req_vld   = 1'b1;
            bus.req_wr    = 1'b1;
            bus.req_addr  = 16'hBEEF;
            bus.req_wdata = 32'h0;
            @(negedge clks);
            chk("stall_vld", bus.rsp_vld, 1);
            chk("stall_data", bus.rsp_rdata, 32'hA5A5_5A5A);
            chk("stall_rdy", bus.req_rdy, 0);
            chk("stall_addr", bus.cpu_addr, 16'h0030);
        end
        bus.req_vld = 1'b0;
        finish_rsp();
        chk("addr_kept", bus.cpu_addr, 16'h0030);

        // reset during strobe
        start(1'b0, 16'h0040, 32'h0);
        @(negedge clks);
        chk("pre_rst_rd", bus.cpu_rd, 1);
        reset = 1'b1;
        @(negedge clks);
        chk("abort_rd", bus.cpu_rd, 0);
        chk("abort_dly", bus.cpu_rd_dly1, 0);
        chk("abort_vld", bus.rsp_vld, 0);
        chk("abort_state", dut.state, IDLE);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clks);
            chk("abort_no_rsp", bus.rsp_vld, 0);
        end
        do_read(16'h0050, 32'h0BAD_F00D, "post_rst_read");

`ifdef CPU_MST_STAT_EN
        do_read(16'h0060, 32'h1111_2222, "stat_rd2");
        do_read(16'h0070, 32'h3333_4444, "stat_rd3");
        start(1'b1, 16'h0080, 32'h5555_6666);
        trace(32'h0, 1'b1);
        finish_rsp();
        chk("stat_rd_cnt", stat_rd_cnt, 3);
        chk("stat_wr_cnt", stat_wr_cnt, 1);
        force dut.u_rd_cnt.cnt = 16'hFFFF;
        @(negedge clks);
        release dut.u_rd_cnt.cnt;
        do_read(16'h0090, 32'h7777_8888, "stat_rd_sat");
        chk("stat_rd_stick", stat_rd_cnt, 16'hFFFF);
        chk("stat_wr_same", stat_wr_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
